// File: rtl/systolic_feeder_if.sv
// -----------------------------------------------------------------------------
// systolic_feeder_if
//   Bundles the word-serial load handshake and the skewed lane outputs of the
//   systolic operand feeder.
//
//   Signals
//     in_valid    upstream -> feeder   in_data carries a valid element
//     in_ready    feeder  -> upstream  feeder accepts a word this cycle
//     in_data     upstream -> feeder   element (W bits)
//     a_out       feeder  -> PE array  row lane i at bits [i*W +: W]
//     a_valid     feeder  -> PE array  row lane i valid
//     b_out       feeder  -> PE array  column lane j at bits [j*W +: W]
//     b_valid     feeder  -> PE array  column lane j valid
//     busy        feeder  -> monitor   high while streaming
//     frame_done  feeder  -> monitor   one-cycle pulse after the last stream cycle
//
//   Modports
//     master : the side that feeds words in and observes the lanes
//     slave  : the feeder itself
// -----------------------------------------------------------------------------
interface systolic_feeder_if #(
  parameter int N = 4,
  parameter int W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [N*W-1:0]   a_out;
  logic [N-1:0]     a_valid;
  logic [N*W-1:0]   b_out;
  logic [N-1:0]     b_valid;
  logic             busy;
  logic             frame_done;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  a_out,
    input  a_valid,
    input  b_out,
    input  b_valid,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output a_out,
    output a_valid,
    output b_out,
    output b_valid,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/systolic_feeder.sv
// -----------------------------------------------------------------------------
// systolic_feeder
//   Buffers one NxN A matrix and one NxN B matrix from a word-serial
//   valid/ready stream (A row-major, then B row-major), then replays them with
//   the diagonal skew a systolic PE array expects: row lane i carries A[i][*]
//   delayed i cycles, column lane j carries B[*][j] delayed j cycles.
//
//   Ports
//     clk     rising-edge clock
//     rst     asynchronous, active-high reset (outputs clear immediately)
//     io_bus  systolic_feeder_if.slave: load handshake in, skewed lanes out
//
//   Sequencing
//     LOAD   (in_ready=1)  2*N*N handshakes fill the buffer
//     STREAM (busy=1)      2N-1 cycles, t = 0..2N-2, lanes show the skewed data
//     DONE                 one cycle, frame_done=1, then back to LOAD
//
//   Every lane/status output is a register loaded from the *next* state and
//   *next* t, so the first skewed values are on the pins in the cycle right
//   after the final load handshake.
// -----------------------------------------------------------------------------
module systolic_feeder #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic              clk,
  input  logic              rst,
  systolic_feeder_if.slave  io_bus
);

  localparam int DEPTH = 2 * N * N;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int T_W   = (2 * N > 1) ? $clog2(2 * N) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [T_W-1:0]   LAST_T   = T_W'(2 * N - 2);

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  // ---------------------------------------------------------------------------
  // State, counters and storage
  // ---------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [T_W-1:0]   r_t;
  logic [W-1:0]     r_mem [DEPTH];

  logic             r_in_ready;
  logic [N*W-1:0]   r_a_out;
  logic [N-1:0]     r_a_valid;
  logic [N*W-1:0]   r_b_out;
  logic [N-1:0]     r_b_valid;
  logic             r_busy;
  logic             r_frame_done;

  logic             w_hs;
  logic [1:0]       w_state_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [T_W-1:0]   w_t_nxt;
  logic [W-1:0]     w_view [DEPTH];
  logic [N*W-1:0]   w_a_nxt;
  logic [N-1:0]     w_a_valid_nxt;
  logic [N*W-1:0]   w_b_nxt;
  logic [N-1:0]     w_b_valid_nxt;

  // in_ready is a register that is only ever high in LOAD, so gating with it
  // is what makes in_valid during STREAM/DONE harmless.
  assign w_hs = io_bus.in_valid & r_in_ready;

  // Next-state, load-index and stream-time computation
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_t_nxt     = r_t;
    case (r_state)
      S_LOAD: begin
        if (w_hs) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_STREAM;
            w_idx_nxt   = {IDX_W{1'b0}};
            w_t_nxt     = {T_W{1'b0}};
          end else begin
            w_idx_nxt   = r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end else begin
          w_idx_nxt = r_idx;
        end
      end
      S_STREAM: begin
        if (r_t == LAST_T) begin
          w_state_nxt = S_DONE;
          w_t_nxt     = {T_W{1'b0}};
        end else begin
          w_t_nxt     = r_t + {{(T_W-1){1'b0}}, 1'b1};
        end
      end
      S_DONE: begin
        w_state_nxt = S_LOAD;
      end
      default: begin
        w_state_nxt = S_LOAD;
        w_idx_nxt   = {IDX_W{1'b0}};
        w_t_nxt     = {T_W{1'b0}};
      end
    endcase
  end

  // Buffer view with the word being accepted this cycle forwarded in, so the
  // t=0 lanes can be computed in the same cycle as the final handshake.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      if (w_hs && (r_idx == IDX_W'(k))) begin
        w_view[k] = io_bus.in_data;
      end else begin
        w_view[k] = r_mem[k];
      end
    end
  end

  // Skewed lane selection for the upcoming cycle; invalid lanes drive zero
  always_comb begin
    w_a_nxt       = {(N*W){1'b0}};
    w_a_valid_nxt = {N{1'b0}};
    w_b_nxt       = {(N*W){1'b0}};
    w_b_valid_nxt = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      int d;
      d = int'(w_t_nxt) - i;
      if ((w_state_nxt == S_STREAM) && (d >= 0) && (d < N)) begin
        // Row lane i: A[i][d] lives at word i*N + d.
        w_a_valid_nxt[i]   = 1'b1;
        w_a_nxt[i*W +: W]  = w_view[IDX_W'(i * N + d)];
        // Column lane i: B[d][i] lives at word N*N + d*N + i.
        w_b_valid_nxt[i]   = 1'b1;
        w_b_nxt[i*W +: W]  = w_view[IDX_W'(N * N + d * N + i)];
      end else begin
        w_a_valid_nxt[i]   = 1'b0;
        w_b_valid_nxt[i]   = 1'b0;
      end
    end
  end

  // Control state, load index and stream time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_LOAD;
      r_idx   <= {IDX_W{1'b0}};
      r_t     <= {T_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_t     <= w_t_nxt;
    end
  end

  // Operand buffer; every frame overwrites all entries, so no clear is needed
  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_mem[r_idx] <= io_bus.in_data;
    end
  end

  // Registered lane and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready   <= 1'b1;
      r_a_out      <= {(N*W){1'b0}};
      r_a_valid    <= {N{1'b0}};
      r_b_out      <= {(N*W){1'b0}};
      r_b_valid    <= {N{1'b0}};
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_in_ready   <= (w_state_nxt == S_LOAD);
      r_a_out      <= w_a_nxt;
      r_a_valid    <= w_a_valid_nxt;
      r_b_out      <= w_b_nxt;
      r_b_valid    <= w_b_valid_nxt;
      r_busy       <= (w_state_nxt == S_STREAM);
      r_frame_done <= (w_state_nxt == S_DONE);
    end
  end

  assign io_bus.in_ready   = r_in_ready;
  assign io_bus.a_out      = r_a_out;
  assign io_bus.a_valid    = r_a_valid;
  assign io_bus.b_out      = r_b_out;
  assign io_bus.b_valid    = r_b_valid;
  assign io_bus.busy       = r_busy;
  assign io_bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_systolic_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_feeder
//   Directed bench for systolic_feeder with N=2, W=32.
//   A=[[1,2],[3,4]], B=[[5,6],[7,8]] (words 1..8); second-frame B=[[9,10],[11,12]].
// -----------------------------------------------------------------------------
module tb_systolic_feeder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  systolic_feeder_if #(.N(2), .W(32)) bus ();

  systolic_feeder #(.N(2), .W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Words 1..4 are A; words 5..8 are B starting at b_base. Optional gaps of
  // k%4 idle cycles before word k; optionally keep in_valid high with 99 after.
  task automatic load(input int nwords, input logic [31:0] b_base,
                      input bit gapped, input bit hold99);
    for (int k = 0; k < nwords; k++) begin
      if (gapped) begin
        for (int g = 0; g < (k % 4); g++) begin
          bus.in_valid = 1'b0;
          bus.in_data  = 32'hDEAD_BEEF;
          step();
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = (k < 4) ? 32'(k + 1) : b_base + 32'(k - 4);
      step();
    end
    if (hold99) begin
      bus.in_data = 32'd99;
    end else begin
      bus.in_valid = 1'b0;
    end
  endtask

  // Called #1 after the final load edge (t=0). Walks STREAM, DONE, LOAD.
  task automatic check_stream(input string tg,
                              input logic [63:0] a0, input logic [63:0] a1, input logic [63:0] a2,
                              input logic [63:0] b0, input logic [63:0] b1, input logic [63:0] b2);
    chk({tg, ".t0.a"},  bus.a_out, a0);
    chk({tg, ".t0.av"}, bus.a_valid, 64'h1);
    chk({tg, ".t0.b"},  bus.b_out, b0);
    chk({tg, ".t0.bv"}, bus.b_valid, 64'h1);
    chk({tg, ".t0.busy"}, bus.busy, 64'h1);
    chk({tg, ".t0.rdy"},  bus.in_ready, 64'h0);
    chk({tg, ".t0.fd"},   bus.frame_done, 64'h0);
    step();
    chk({tg, ".t1.a"},  bus.a_out, a1);
    chk({tg, ".t1.av"}, bus.a_valid, 64'h3);
    chk({tg, ".t1.b"},  bus.b_out, b1);
    chk({tg, ".t1.bv"}, bus.b_valid, 64'h3);
    chk({tg, ".t1.rdy"}, bus.in_ready, 64'h0);
    chk({tg, ".t1.fd"},  bus.frame_done, 64'h0);
    step();
    chk({tg, ".t2.a"},  bus.a_out, a2);
    chk({tg, ".t2.av"}, bus.a_valid, 64'h2);
    chk({tg, ".t2.b"},  bus.b_out, b2);
    chk({tg, ".t2.bv"}, bus.b_valid, 64'h2);
    chk({tg, ".t2.rdy"}, bus.in_ready, 64'h0);
    chk({tg, ".t2.fd"},  bus.frame_done, 64'h0);
    step();
    chk({tg, ".done.fd"},   bus.frame_done, 64'h1);
    chk({tg, ".done.av"},   bus.a_valid, 64'h0);
    chk({tg, ".done.bv"},   bus.b_valid, 64'h0);
    chk({tg, ".done.a"},    bus.a_out, 64'h0);
    chk({tg, ".done.rdy"},  bus.in_ready, 64'h0);
    chk({tg, ".done.busy"}, bus.busy, 64'h0);
    step();
    chk({tg, ".load.fd"},  bus.frame_done, 64'h0);
    chk({tg, ".load.rdy"}, bus.in_ready, 64'h1);
    bus.in_valid = 1'b0;
  endtask

  logic [63:0] ea0, ea1, ea2, eb0, eb1, eb2, fb0, fb1, fb2;

  initial begin
    checks = 0;
    errors = 0;
    // Lane 1 in the upper word, lane 0 in the lower word.
    ea0 = {32'd0, 32'd1};  ea1 = {32'd3, 32'd2};  ea2 = {32'd4, 32'd0};
    eb0 = {32'd0, 32'd5};  eb1 = {32'd6, 32'd7};  eb2 = {32'd8, 32'd0};
    fb0 = {32'd0, 32'd9};  fb1 = {32'd10, 32'd11}; fb2 = {32'd12, 32'd0};

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'd0;
    #3;
    chk("rst.rdy",  bus.in_ready, 64'h1);
    chk("rst.a",    bus.a_out, 64'h0);
    chk("rst.b",    bus.b_out, 64'h0);
    chk("rst.av",   bus.a_valid, 64'h0);
    chk("rst.bv",   bus.b_valid, 64'h0);
    chk("rst.busy", bus.busy, 64'h0);
    chk("rst.fd",   bus.frame_done, 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("rel.rdy", bus.in_ready, 64'h1);

    // 1: back-to-back load
    load(8, 32'd5, 1'b0, 1'b0);
    check_stream("c1", ea0, ea1, ea2, eb0, eb1, eb2);

    // 2: gaps of 0-3 cycles between words
    load(8, 32'd5, 1'b1, 1'b0);
    check_stream("c2", ea0, ea1, ea2, eb0, eb1, eb2);

    // 3: in_valid held with 99 through STREAM/DONE; a clean reload proves 99 was not taken
    load(8, 32'd5, 1'b0, 1'b1);
    check_stream("c3", ea0, ea1, ea2, eb0, eb1, eb2);
    load(8, 32'd5, 1'b0, 1'b0);
    check_stream("c3b", ea0, ea1, ea2, eb0, eb1, eb2);

    // 4: reset after 5 words, outputs clear with no clock edge
    load(5, 32'd5, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("c4.rdy", bus.in_ready, 64'h1);
    chk("c4.av",  bus.a_valid, 64'h0);
    chk("c4.bv",  bus.b_valid, 64'h0);
    chk("c4.a",   bus.a_out, 64'h0);
    chk("c4.b",   bus.b_out, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    load(8, 32'd5, 1'b0, 1'b0);
    check_stream("c4b", ea0, ea1, ea2, eb0, eb1, eb2);

    // 5: reset during STREAM at t=1
    load(8, 32'd5, 1'b0, 1'b0);
    chk("c5.t0.av", bus.a_valid, 64'h1);
    step();
    chk("c5.t1.av", bus.a_valid, 64'h3);
    rst = 1'b1;
    #1;
    chk("c5.av",   bus.a_valid, 64'h0);
    chk("c5.bv",   bus.b_valid, 64'h0);
    chk("c5.busy", bus.busy, 64'h0);
    chk("c5.rdy",  bus.in_ready, 64'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("c5.nofd", bus.frame_done, 64'h0);
    end
    load(8, 32'd5, 1'b0, 1'b0);
    check_stream("c5b", ea0, ea1, ea2, eb0, eb1, eb2);

    // 6: two consecutive frames, second with B=[[9,10],[11,12]]
    load(8, 32'd5, 1'b0, 1'b0);
    check_stream("c6a", ea0, ea1, ea2, eb0, eb1, eb2);
    load(8, 32'd9, 1'b0, 1'b0);
    check_stream("c6b", ea0, ea1, ea2, fb0, fb1, fb2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
